capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  8  sample width, equal to the FIFO WIDTH
  CAP_LEN  256  samples per capture, 1..2**9
  TIMEOUT  1000000  auto-trigger cycles, used only with TRIG_TIMEOUT_EN
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock
  rst_n  in  1  reset, asynchronous and active-low
  arm  in  1  start-capture pulse
  abort  in  1  cancel and discard
  trig_level  in  WIDTH  trigger threshold, unsigned
  trig_fall  in  1  0 = rising edge, 1 = falling edge
  adc_data  in  WIDTH  sample
  adc_valid  in  1  sample strobe
  fifo_in  out  WIDTH  to FIFO in
  fifo_push  out  1  to FIFO push
  fifo_pop  out  1  to FIFO pop
  fifo_out  in  WIDTH  from FIFO out, valid the cycle after pop
  fifo_empty  in  1  FIFO is_empty
  fifo_full  in  1  FIFO is_full
  rd_data  out  WIDTH  readout data
  rd_valid  out  1  readout valid
  rd_ready  in  1  consumer ready
  busy  out  1  state is not IDLE
  done  out  1  one-cycle pulse at the end of readout
  short_cap  out  1  sticky flag: capture ended on fifo_full before CAP_LEN

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_TRIG, CAPTURE, READOUT and FLUSH.
REQ-004 In IDLE, arm SHALL go to WAIT_TRIG if fifo_empty; otherwise it goes to FLUSH with arm_pend=1; arm in any other state is ignored.
REQ-005 The previous-sample register SHALL update on every adc_valid, and SHALL invalidate on entry to WAIT_TRIG.
  - Rising trigger: prev < trig_level and adc_data >= trig_level.
  - Falling trigger: prev > trig_level and adc_data <= trig_level.
REQ-006 The trigger sample SHALL be pushed in the same cycle it is detected.
  - fifo_in = adc_data and fifo_push = 1 combinationally.
  - Sample counter set to 1; state goes to CAPTURE.
REQ-007 In CAPTURE, each adc_valid with !fifo_full SHALL push and increment the counter; the counter is 9+1 bits and unsigned.
REQ-008 CAPTURE SHALL end at the cycle count reaches CAP_LEN, or at the first adc_valid seen with fifo_full, which sets short_cap; then go to READOUT.
REQ-009 In READOUT, fifo_pop SHALL be asserted when !fifo_empty and (!rd_valid or rd_ready).
  - rd_valid is registered: set the cycle after a pop, cleared on rd_ready without a new pop.
  - rd_data = fifo_out.
REQ-010 When fifo_empty, !rd_valid and no pop is in flight, READOUT SHALL pulse done for one cycle and go to IDLE.
REQ-011 abort in WAIT_TRIG, CAPTURE or READOUT SHALL clear rd_valid and go to FLUSH with arm_pend=0; abort has priority over arm and over the trigger in the same cycle.
REQ-012 FLUSH SHALL pop every cycle while !fifo_empty, discard the data and keep rd_valid at 0.
  - On fifo_empty: go to WAIT_TRIG if arm_pend, else IDLE.
REQ-013 fifo_push SHALL never be asserted outside WAIT_TRIG or CAPTURE; fifo_pop SHALL never be asserted outside READOUT or FLUSH; the two SHALL never be asserted together.
REQ-014 short_cap SHALL clear when arm is accepted.

Reset
REQ-015 On rst_n low, asynchronously, the block SHALL reset as follows.
  - State IDLE.
  - Counters, prev-valid, arm_pend and the timeout counter = 0.
  - fifo_push, fifo_pop, rd_valid, busy, done and short_cap = 0; fifo_in and rd_data = 0.
REQ-016 A reset mid-capture SHALL leave FIFO contents stale; the next arm SHALL flush them through REQ-004.

Configuration
REQ-017 With TRIG_TIMEOUT_EN defined, a counter SHALL run in WAIT_TRIG; after TIMEOUT cycles with no trigger, the next adc_valid is forced as the trigger sample.
REQ-018 Without TRIG_TIMEOUT_EN, WAIT_TRIG SHALL wait indefinitely and no timeout logic exists.

Structure
REQ-019 Package capture_pkg SHALL hold the state enum cap_state_t and the FIFO BASE constant (9).
REQ-020 Sub-module trig_detect SHALL hold the prev register and the crossing compare; the FSM and counters stay in capture_ctrl, and the fifo instance stays outside.

Verification
REQ-021 Rising capture: level=0x80, samples 0x10,0x70,0x90,…, CAP_LEN=4 -> 0x90 plus the next 3 samples pushed, 4 rd_valid beats in order, done pulse, short_cap=0.
REQ-022 Falling capture: trig_fall=1, samples 0x90,0x85,0x80 -> trigger on 0x80; 0x85 is not pushed.
REQ-023 Backpressure: rd_ready low 5 cycles mid-readout -> rd_data held, no pop while rd_valid && !rd_ready, no beat lost.
REQ-024 Abort in CAPTURE after 3 pushes -> 3 pops in FLUSH, rd_valid stays 0, then IDLE with fifo_empty.
REQ-025 FIFO pre-filled with 2 entries and arm -> FLUSH pops 2, then WAIT_TRIG.
REQ-026 With TRIG_TIMEOUT_EN and TIMEOUT=16, a flat input of 0x00 -> forced trigger on the first adc_valid after 16 cycles.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and constants for the capture controller slice.
package capture_pkg;

  localparam int BASE  = 9;
  localparam int CNT_W = BASE + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    CAPTURE   = 3'd2,
    READOUT   = 3'd3,
    FLUSH     = 3'd4
  } cap_state_t;

endpackage

// File: rtl/trig_detect.sv
// Threshold-crossing detector: remembers the previous sample and flags a
// rising or falling crossing of trig_level on the current sample.
module trig_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adc_valid,
  input  logic             trig_fall,
  input  logic [WIDTH-1:0] adc_data,
  input  logic [WIDTH-1:0] trig_level,
  output logic             hit
);

  logic [WIDTH-1:0] prev_r;
  logic             prev_valid_r;

  // Previous-sample register; clr drops validity so a stale sample cannot trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
    end else begin
      if (adc_valid) begin
        prev_r <= adc_data;
      end
      if (clr) begin
        prev_valid_r <= 1'b0;
      end else if (adc_valid) begin
        prev_valid_r <= 1'b1;
      end
    end
  end

  // Crossing compare against the threshold, unsigned
  always_comb begin
    hit = 1'b0;
    if (adc_valid && prev_valid_r) begin
      if (trig_fall) begin
        hit = (prev_r > trig_level) && (adc_data <= trig_level);
      end else begin
        hit = (prev_r < trig_level) && (adc_data >= trig_level);
      end
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Triggered capture into an external FIFO followed by a ready/valid readout.
// Optional auto-trigger after TIMEOUT idle cycles: define TRIG_TIMEOUT_EN.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CAP_LEN = 256,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_fall,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_valid,
  output logic [WIDTH-1:0] fifo_in,
  output logic             fifo_push,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             short_cap
);

  localparam logic [CNT_W-1:0] CAP_LEN_C = CNT_W'(CAP_LEN);

  cap_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             arm_pend_r;
  logic             rd_valid_r;
  logic             done_r;
  logic             short_cap_r;

  logic             hit_s;
  logic             trig_s;
  logic             push_s;
  logic             pop_s;
  logic             enter_wait_s;

  trig_detect #(
    .WIDTH(WIDTH)
  ) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (enter_wait_s),
    .adc_valid (adc_valid),
    .trig_fall (trig_fall),
    .adc_data  (adc_data),
    .trig_level(trig_level),
    .hit       (hit_s)
  );

`ifdef TRIG_TIMEOUT_EN
  localparam int             TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt_r;

  // Wait-for-trigger timer, saturating at TIMEOUT and restarted on each entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (enter_wait_s) begin
      to_cnt_r <= '0;
    end else if ((state_r == WAIT_TRIG) && (to_cnt_r != TO_MAX)) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign trig_s = hit_s || ((to_cnt_r == TO_MAX) && adc_valid);
`else
  assign trig_s = hit_s;
`endif

  // FIFO strobes: the trigger sample must land in the same cycle it is seen
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    enter_wait_s = 1'b0;
    case (state_r)
      IDLE:      enter_wait_s = arm && fifo_empty;
      WAIT_TRIG: push_s = !abort && trig_s;
      CAPTURE:   push_s = !abort && adc_valid && !fifo_full;
      READOUT:   pop_s  = !abort && !fifo_empty && (!rd_valid_r || rd_ready);
      FLUSH: begin
        pop_s        = !fifo_empty;
        enter_wait_s = fifo_empty && arm_pend_r;
      end
      default: begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        enter_wait_s = 1'b0;
      end
    endcase
  end

  // Main control FSM with sample counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      arm_pend_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      short_cap_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (arm) begin
            short_cap_r <= 1'b0;
            if (fifo_empty) begin
              state_r <= WAIT_TRIG;
            end else begin
              state_r    <= FLUSH;
              arm_pend_r <= 1'b1;
            end
          end
        end
        WAIT_TRIG: begin
          if (abort) begin
            state_r    <= FLUSH;
            arm_pend_r <= 1'b0;
            rd_valid_r <= 1'b0;
          end else if (trig_s) begin
            cnt_r   <= CNT_W'(1);
            state_r <= (CAP_LEN_C == CNT_W'(1)) ? READOUT : CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state_r    <= FLUSH;
            arm_pend_r <= 1'b0;
            rd_valid_r <= 1'b0;
          end else if (adc_valid) begin
            if (fifo_full) begin
              short_cap_r <= 1'b1;
              state_r     <= READOUT;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
              if ((cnt_r + CNT_W'(1)) == CAP_LEN_C) begin
                state_r <= READOUT;
              end
            end
          end
        end
        READOUT: begin
          if (abort) begin
            state_r    <= FLUSH;
            arm_pend_r <= 1'b0;
            rd_valid_r <= 1'b0;
          end else begin
            if (pop_s) begin
              rd_valid_r <= 1'b1;
            end else if (rd_ready) begin
              rd_valid_r <= 1'b0;
            end
            // A pop always needs a non-empty FIFO, so empty here means none in flight
            if (fifo_empty && !rd_valid_r) begin
              done_r  <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        FLUSH: begin
          rd_valid_r <= 1'b0;
          if (fifo_empty) begin
            state_r    <= arm_pend_r ? WAIT_TRIG : IDLE;
            arm_pend_r <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign fifo_push = push_s;
  assign fifo_pop  = pop_s;
  assign fifo_in   = push_s ? adc_data : '0;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_valid_r ? fifo_out : '0;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign short_cap = short_cap_r;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with a behavioural FIFO and readout scoreboard.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] trig_level = 8'h80;
  logic       trig_fall = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       adc_valid = 1'b0;
  logic [7:0] fifo_in;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_out = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b1;
  logic       busy;
  logic       done;
  logic       short_cap;

  int vectors = 0;
  int miscompares = 0;
  int beats = 0;
  bit rv_seen = 1'b0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int depth_lim = 16;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  capture_ctrl #(.WIDTH(8), .CAP_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .trig_level(trig_level), .trig_fall(trig_fall),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .fifo_in(fifo_in), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_out(fifo_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .short_cap(short_cap)
  );

  always #5 clk = ~clk;

  // FIFO model with registered output and flags
  always @(posedge clk) begin
    if (fifo_push && (fifo_q.size() < depth_lim)) begin
      fifo_q.push_back(fifo_in);
      push_cnt <= push_cnt + 1;
    end
    if (fifo_pop && (fifo_q.size() > 0)) begin
      fifo_out <= fifo_q.pop_front();
      pop_cnt  <= pop_cnt + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
    fifo_full  <= (fifo_q.size() >= depth_lim);
  end

  // Readout scoreboard and strobe exclusivity monitor
  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (rst_n) begin
      vectors++;
      if (fifo_push && fifo_pop) begin
        miscompares++;
        $display("FAIL push_pop_overlap: push=%b pop=%b, required not both", fifo_push, fifo_pop);
      end
      if (rd_valid) rv_seen = 1'b1;
      if (rd_valid && rd_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: rd_data=%h with no beat expected", rd_data);
        end else begin
          e = exp_q.pop_front();
          beats++;
          if (rd_data !== e) begin
            miscompares++;
            $display("FAIL rd_data: got %h, required %h", rd_data, e);
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic a, input logic ab);
    @(negedge clk);
    adc_valid = v;
    adc_data  = d;
    arm       = a;
    abort     = ab;
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #2;
      vectors++;
      if ({fifo_push, fifo_pop, rd_valid, busy, done, short_cap} !== 6'b0 ||
          fifo_in !== 8'h00 || rd_data !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_outputs: push/pop/rv/busy/done/short=%b%b%b%b%b%b in=%h rd=%h, required all 0",
                 fifo_push, fifo_pop, rd_valid, busy, done, short_cap, fifo_in, rd_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rising();
    logic [7:0] smp [7];
    logic [6:0] ep;
    int p0;
    bit got;
    smp = '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    ep  = 7'b0111100;
    trig_fall = 1'b0; trig_level = 8'h80; rd_ready = 1'b1; beats = 0; p0 = push_cnt;
    exp_q.push_back(8'h90); exp_q.push_back(8'hA0); exp_q.push_back(8'hB0); exp_q.push_back(8'hC0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, smp[i], 1'b0, 1'b0);
      vectors++;
      if (fifo_push !== ep[i] || (ep[i] && fifo_in !== smp[i])) begin
        miscompares++;
        $display("FAIL rise_push[%0d]: push=%b in=%h, required push=%b in=%h", i, fifo_push, fifo_in, ep[i], smp[i]);
      end
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (done) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL rise_done: no done pulse within 40 cycles"); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || short_cap !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_end: done=%b busy=%b short=%b, required 0 0 0", done, busy, short_cap);
    end
    vectors++;
    if (push_cnt - p0 != 4 || beats != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rise_counts: pushes=%0d beats=%0d left=%0d, required 4 4 0", push_cnt - p0, beats, exp_q.size());
    end
  endtask

  task automatic test_falling();
    logic [7:0] smp [6];
    logic [5:0] ep;
    int p0;
    bit got;
    smp = '{8'h90, 8'h85, 8'h80, 8'h70, 8'h60, 8'h50};
    ep  = 6'b111100;
    trig_fall = 1'b1; trig_level = 8'h80; rd_ready = 1'b1; beats = 0; p0 = push_cnt;
    exp_q.push_back(8'h80); exp_q.push_back(8'h70); exp_q.push_back(8'h60); exp_q.push_back(8'h50);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, smp[i], 1'b0, 1'b0);
      vectors++;
      if (fifo_push !== ep[i] || (ep[i] && fifo_in !== smp[i])) begin
        miscompares++;
        $display("FAIL fall_push[%0d]: push=%b in=%h, required push=%b in=%h", i, fifo_push, fifo_in, ep[i], smp[i]);
      end
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (done) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || push_cnt - p0 != 4 || beats != 4) begin
      miscompares++;
      $display("FAIL fall_summary: done=%b pushes=%0d beats=%0d, required 1 4 4", got, push_cnt - p0, beats);
    end
    trig_fall = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] smp [5];
    int low;
    bit got;
    smp = '{8'h10, 8'h90, 8'h91, 8'h92, 8'h93};
    rd_ready = 1'b1; beats = 0; low = 0;
    exp_q.push_back(8'h90); exp_q.push_back(8'h91); exp_q.push_back(8'h92); exp_q.push_back(8'h93);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, smp[i], 1'b0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (beats >= 1 && low < 5) begin rd_ready = 1'b0; low++; end
      else rd_ready = 1'b1;
      #2;
      if (!rd_ready) begin
        vectors++;
        if (rd_valid !== 1'b1 || fifo_pop !== 1'b0 || rd_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL bp_hold: rv=%b pop=%b rd=%h, required 1 0 %h", rd_valid, fifo_pop, rd_data, exp_q[0]);
        end
      end
      if (done) begin got = 1'b1; break; end
    end
    rd_ready = 1'b1;
    vectors++;
    if (!got || low != 5 || beats != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_summary: done=%b low=%0d beats=%0d left=%0d, required 1 5 4 0", got, low, beats, exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] smp [4];
    int q0;
    bit got;
    smp = '{8'h10, 8'h90, 8'h91, 8'h92};
    rv_seen = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, smp[i], 1'b0, 1'b0);
    q0 = pop_cnt;
    cyc(1'b1, 8'h93, 1'b0, 1'b1);
    vectors++;
    if (fifo_push !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_priority: push=%b, required 0", fifo_push);
    end
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (!busy) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || pop_cnt - q0 != 3 || rv_seen || fifo_empty !== 1'b1 || fifo_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_flush: idle=%b pops=%0d rv_seen=%b empty=%b, required 1 3 0 1", got, pop_cnt - q0, rv_seen, fifo_empty);
    end
  endtask

  task automatic test_prefill();
    int q0;
    bit got;
    @(negedge clk);
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
    fifo_empty <= 1'b0;
    q0 = pop_cnt; rv_seen = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (pop_cnt - q0 != 2 || busy !== 1'b1 || fifo_empty !== 1'b1 || rv_seen) begin
      miscompares++;
      $display("FAIL prefill_flush: pops=%0d busy=%b empty=%b rv_seen=%b, required 2 1 1 0", pop_cnt - q0, busy, fifo_empty, rv_seen);
    end
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 8'h90, 1'b0, 1'b0);
    vectors++;
    if (fifo_push !== 1'b1) begin
      miscompares++;
      $display("FAIL prefill_wait_trig: push=%b, required 1", fifo_push);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (!busy) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || fifo_q.size() != 0) begin
      miscompares++;
      $display("FAIL prefill_idle: idle=%b left=%0d, required 1 0", got, fifo_q.size());
    end
  endtask

  task automatic test_short_cap();
    logic [7:0] smp [4];
    logic [3:0] ep;
    bit got;
    smp = '{8'h10, 8'h90, 8'h91, 8'h92};
    ep  = 4'b0110;
    depth_lim = 2; beats = 0; rd_ready = 1'b1;
    exp_q.push_back(8'h90); exp_q.push_back(8'h91);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, smp[i], 1'b0, 1'b0);
      vectors++;
      if (fifo_push !== ep[i]) begin
        miscompares++;
        $display("FAIL short_push[%0d]: push=%b, required %b", i, fifo_push, ep[i]);
      end
    end
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (done) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || short_cap !== 1'b1 || beats != 2) begin
      miscompares++;
      $display("FAIL short_cap_set: done=%b short=%b beats=%0d, required 1 1 2", got, short_cap, beats);
    end
    depth_lim = 16;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (short_cap !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL short_cap_clear: short=%b busy=%b, required 0 1", short_cap, busy);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short_abort_idle: busy=%b, required 0", busy);
    end
  endtask

`ifdef TRIG_TIMEOUT_EN
  task automatic test_timeout();
    int first;
    int npush;
    bit got;
    trig_fall = 1'b0; trig_level = 8'h80; rd_ready = 1'b1; beats = 0;
    first = -1; npush = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'h00, 1'b0, 1'b0);
      if (fifo_push) begin
        if (first < 0) first = i;
        npush++;
        if (npush == 4) break;
      end
    end
    vectors++;
    if (first != 16) begin
      miscompares++;
      $display("FAIL timeout_index: first push at wait cycle %0d, required 16", first);
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (done) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || beats != 4) begin
      miscompares++;
      $display("FAIL timeout_readout: done=%b beats=%0d, required 1 4", got, beats);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_backpressure();
    test_abort();
    test_prefill();
    test_short_cap();
`ifdef TRIG_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
